// File: rtl/trdb_pkg.sv
// trdb_pkg: shared types for the trace trigger unit
package trdb_pkg;
  typedef enum logic [1:0] {
    DISARMED   = 2'd0,
    WAIT_START = 2'd1,
    TRACING    = 2'd2,
    STOP_WAIT  = 2'd3
  } trig_state_e;
  typedef enum logic {
    TRIG_SINGLE = 1'b0,
    TRIG_REPEAT = 1'b1
  } trig_mode_e;
endpackage

// File: rtl/trdb_trigger_if.sv
// trdb_trigger_if: config, retired-instruction stream and trace request bundle
interface trdb_trigger_if #(
  parameter int XLEN    = 32,
  parameter int DELAY_W = 8
);
  logic               arm_i;
  logic               mode_i;
  logic               start_en_i;
  logic               stop_en_i;
  logic [XLEN-1:0]    start_addr_i;
  logic [XLEN-1:0]    stop_addr_i;
  logic [DELAY_W-1:0] stop_delay_i;
  logic               inst_valid_i;
  logic [XLEN-1:0]    iaddr_i;
  logic               trace_req_on_o;
  logic               trace_req_off_o;
  logic               tracing_o;
  logic [1:0]         state_o;
  modport master (
    output arm_i, mode_i, start_en_i, stop_en_i, start_addr_i, stop_addr_i,
           stop_delay_i, inst_valid_i, iaddr_i,
    input  trace_req_on_o, trace_req_off_o, tracing_o, state_o
  );
  modport slave (
    input  arm_i, mode_i, start_en_i, stop_en_i, start_addr_i, stop_addr_i,
           stop_delay_i, inst_valid_i, iaddr_i,
    output trace_req_on_o, trace_req_off_o, tracing_o, state_o
  );
endinterface

// File: rtl/trdb_trigger.sv
// trdb_trigger: address-match start/stop trigger with retired-instruction stop hold-off
module trdb_trigger
  import trdb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DELAY_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  trdb_trigger_if.slave bus
);
  trig_state_e        state_q, state_d, exit_st;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic               arm_prev_q;
  logic               on_q, on_d, off_q, off_d;
  logic               start_hit, stop_hit, last, in_trace, stop_now;
  assign start_hit = bus.inst_valid_i & bus.start_en_i & (bus.iaddr_i[XLEN-1:0] == bus.start_addr_i[XLEN-1:0]);
  assign stop_hit  = bus.inst_valid_i & bus.stop_en_i & (bus.iaddr_i[XLEN-1:0] == bus.stop_addr_i[XLEN-1:0]);
  assign last      = bus.inst_valid_i & (cnt_q == DELAY_W'(1));
  assign in_trace  = (state_q == TRACING) | (state_q == STOP_WAIT);
  assign stop_now  = ((state_q == TRACING) & stop_hit & (bus.stop_delay_i == '0)) | ((state_q == STOP_WAIT) & last);
  assign exit_st   = (trig_mode_e'(bus.mode_i) == TRIG_REPEAT) ? WAIT_START : DISARMED;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= DISARMED;
      cnt_q      <= '0;
      arm_prev_q <= 1'b0;
      on_q       <= 1'b0;
      off_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arm_prev_q <= bus.arm_i;
      on_q       <= on_d;
      off_q      <= off_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISARMED:   state_d = (bus.arm_i & ~arm_prev_q) ? WAIT_START : DISARMED;
      WAIT_START: state_d = start_hit ? TRACING : WAIT_START;
      TRACING:    state_d = !stop_hit ? TRACING : (bus.stop_delay_i == '0) ? exit_st : STOP_WAIT;
      STOP_WAIT:  state_d = last ? exit_st : STOP_WAIT;
      default:    state_d = DISARMED;
    endcase
    if (!bus.arm_i) state_d = DISARMED;
  end
  always_comb begin
    on_d  = bus.arm_i & (state_q == WAIT_START) & start_hit;
    off_d = in_trace & (~bus.arm_i | stop_now);
    cnt_d = !bus.arm_i ? '0 :
            ((state_q == TRACING) & stop_hit) ? bus.stop_delay_i :
            ((state_q == STOP_WAIT) & bus.inst_valid_i & (cnt_q != '0)) ? cnt_q - DELAY_W'(1) :
            cnt_q;
  end
  assign bus.trace_req_on_o  = on_q;
  assign bus.trace_req_off_o = off_q;
  assign bus.tracing_o       = in_trace;
  assign bus.state_o         = state_q;
endmodule

// File: tb/tb_trdb_trigger.sv
// tb_trdb_trigger: directed checks of start/stop pulses, hold-off, single-shot, disarm and reset
module tb_trdb_trigger;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  trdb_trigger_if #(.XLEN(32), .DELAY_W(8)) bus ();
  trdb_trigger #(.XLEN(32), .DELAY_W(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic on, input logic off, input logic tr, input logic [1:0] st);
    chk({tag, ".on"}, 32'(bus.trace_req_on_o), 32'(on));
    chk({tag, ".off"}, 32'(bus.trace_req_off_o), 32'(off));
    chk({tag, ".tracing"}, 32'(bus.tracing_o), 32'(tr));
    chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
  endtask
  task automatic ret(input logic [31:0] a);
    @(negedge clk);
    bus.inst_valid_i = 1'b1;
    bus.iaddr_i = a;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    @(negedge clk);
    bus.inst_valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.arm_i = 1'b0;
    bus.mode_i = 1'b1;
    bus.start_en_i = 1'b1;
    bus.stop_en_i = 1'b1;
    bus.start_addr_i = 32'h100;
    bus.stop_addr_i = 32'h200;
    bus.stop_delay_i = 8'd0;
    bus.inst_valid_i = 1'b0;
    bus.iaddr_i = '0;
    #12;
    outs("reset", 0, 0, 0, 2'd0);
    chk("reset.cnt", 32'(dut.cnt_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.arm_i = 1'b1;
    idle();
    outs("armed", 0, 0, 0, 2'd1);
    ret(32'h0FC);
    outs("miss", 0, 0, 0, 2'd1);
    ret(32'h100);
    outs("start", 1, 0, 1, 2'd2);
    ret(32'h104);
    outs("trace", 0, 0, 1, 2'd2);
    ret(32'h200);
    outs("stop0", 0, 1, 0, 2'd1);
    idle();
    outs("after_stop0", 0, 0, 0, 2'd1);
    bus.stop_delay_i = 8'd3;
    ret(32'h100);
    outs("hold.start", 1, 0, 1, 2'd2);
    ret(32'h200);
    outs("hold.stop", 0, 0, 1, 2'd3);
    idle();
    outs("hold.idle1", 0, 0, 1, 2'd3);
    ret(32'h204);
    outs("hold.v1", 0, 0, 1, 2'd3);
    idle();
    outs("hold.idle2", 0, 0, 1, 2'd3);
    ret(32'h208);
    outs("hold.v2", 0, 0, 1, 2'd3);
    ret(32'h20C);
    outs("hold.v3", 0, 1, 0, 2'd1);
    bus.stop_delay_i = 8'd0;
    bus.start_addr_i = 32'h300;
    bus.stop_addr_i = 32'h300;
    ret(32'h300);
    outs("same.first", 1, 0, 1, 2'd2);
    ret(32'h300);
    outs("same.second", 0, 1, 0, 2'd1);
    bus.start_addr_i = 32'h100;
    bus.stop_addr_i = 32'h200;
    bus.mode_i = 1'b0;
    ret(32'h100);
    outs("single.start", 1, 0, 1, 2'd2);
    ret(32'h200);
    outs("single.stop", 0, 1, 0, 2'd0);
    ret(32'h100);
    outs("single.ignored", 0, 0, 0, 2'd0);
    idle();
    outs("single.stay", 0, 0, 0, 2'd0);
    bus.arm_i = 1'b0;
    idle();
    outs("single.arm0", 0, 0, 0, 2'd0);
    bus.arm_i = 1'b1;
    idle();
    outs("single.rearm", 0, 0, 0, 2'd1);
    bus.stop_delay_i = 8'd3;
    ret(32'h100);
    outs("disarm.start", 1, 0, 1, 2'd2);
    ret(32'h200);
    outs("disarm.stop", 0, 0, 1, 2'd3);
    ret(32'h204);
    chk("disarm.cnt2", 32'(dut.cnt_q), 2);
    bus.arm_i = 1'b0;
    idle();
    outs("disarm.drop", 0, 1, 0, 2'd0);
    chk("disarm.cnt0", 32'(dut.cnt_q), 0);
    idle();
    outs("disarm.after", 0, 0, 0, 2'd0);
    bus.mode_i = 1'b1;
    bus.stop_delay_i = 8'd0;
    bus.arm_i = 1'b1;
    idle();
    outs("rst.rearm", 0, 0, 0, 2'd1);
    ret(32'h100);
    outs("rst.start", 1, 0, 1, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    outs("rst.async", 0, 0, 0, 2'd0);
    @(negedge clk);
    bus.inst_valid_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    outs("rst.release", 0, 0, 0, 2'd1);
    idle();
    outs("rst.quiet", 0, 0, 0, 2'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
